// File: rtl/la_capture_core_if.sv
// Probe, trigger-config, control and readout bundle for la_capture_core.
// master drives probes/config/readout requests; slave is the capture core.
interface la_capture_core_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] probe_i;
  logic             arm_i;
  logic             abort_i;
  logic [1:0]       trig_mode_i;
  logic [WIDTH-1:0] trig_value_i;
  logic [WIDTH-1:0] trig_mask_i;
  logic [AW-1:0]    pre_count_i;
  logic [3:0]       trig_count_i;
  logic             rd_en_i;
  logic [AW-1:0]    rd_addr_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_valid_o;
  logic [2:0]       state_o;
  logic             triggered_o;
  logic             done_o;
  logic [AW-1:0]    trig_pos_o;

  modport master (
    output probe_i, arm_i, abort_i,
    output trig_mode_i, trig_value_i,
    output trig_mask_i, pre_count_i,
    output trig_count_i,
    output rd_en_i, rd_addr_i,
    input  rd_data_o, rd_valid_o,
    input  state_o, triggered_o,
    input  done_o, trig_pos_o
  );

  modport slave (
    input  probe_i, arm_i, abort_i,
    input  trig_mode_i, trig_value_i,
    input  trig_mask_i, pre_count_i,
    input  trig_count_i,
    input  rd_en_i, rd_addr_i,
    output rd_data_o, rd_valid_o,
    output state_o, triggered_o,
    output done_o, trig_pos_o
  );
endinterface

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular probe buffer with programmable
// trigger, occurrence count, pre-trigger window and random-access readout.
module la_capture_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
) (
  input logic clk_i,
  input logic rst_i,
  la_capture_core_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] mask;
    logic [AW-1:0]    pre;
    logic [3:0]       tc;
  } cfg_t;

  state_t           state;
  cfg_t             cfg;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    fill;
  logic [AW-1:0]    post_left;
  logic [3:0]       occ;
  logic [WIDTH-1:0] prev;
  logic             first_wait;
  logic [AW-1:0]    trig_addr;
  logic             triggered;
  logic             done;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             capturing;
  logic             wr_en;
  logic             arm_go;
  logic [WIDTH-1:0] cur_m;
  logic [WIDTH-1:0] prev_m;
  logic             hit;
  logic [3:0]       occ_inc;
  logic [3:0]       tc_eff;
  logic             fire;
  logic [AW-1:0]    post_init;
  logic [AW-1:0]    start;
  logic [AW-1:0]    rd_phys;

  assign capturing = (state == S_PRE) ||
                     (state == S_WAIT) ||
                     (state == S_POST);
  assign wr_en = capturing && !rst_i;

  assign arm_go = bus.arm_i && !bus.abort_i &&
                  ((state == S_IDLE) ||
                   (state == S_DONE));

  assign cur_m  = bus.probe_i & cfg.mask;
  assign prev_m = prev & cfg.mask;

  always_comb begin
    hit = 1'b0;
    unique case (cfg.mode)
      2'b00: hit = (cur_m == (cfg.value & cfg.mask));
      2'b01: hit = |(~prev_m & cur_m);
      2'b10: hit = |(prev_m & ~cur_m);
      2'b11: hit = first_wait;
    endcase
  end

  // Occurrence counter saturates at 15; a programmed 0 means "first hit".
  assign occ_inc = (occ == 4'hF) ? occ : occ + 4'd1;
  assign tc_eff  = (cfg.tc == 4'd0) ? 4'd1 : cfg.tc;
  assign fire    = (state == S_WAIT) && hit &&
                   (occ_inc == tc_eff);

  assign post_init = {AW{1'b1}} - cfg.pre;
  assign start     = trig_addr - cfg.pre;
  assign rd_phys   = start + bus.rd_addr_i;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.probe_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cfg        <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      post_left  <= '0;
      occ        <= '0;
      prev       <= '0;
      first_wait <= 1'b0;
      trig_addr  <= '0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      prev     <= bus.probe_i;
      rd_valid <= 1'b0;
      if ((state == S_DONE) && bus.rd_en_i) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_phys];
      end

      unique case (1'b1)
        bus.abort_i: begin
          state     <= S_IDLE;
          triggered <= 1'b0;
          done      <= 1'b0;
        end
        arm_go: begin
          cfg.mode   <= bus.trig_mode_i;
          cfg.value  <= bus.trig_value_i;
          cfg.mask   <= bus.trig_mask_i;
          cfg.pre    <= bus.pre_count_i;
          cfg.tc     <= bus.trig_count_i;
          wr_ptr     <= '0;
          fill       <= '0;
          occ        <= '0;
          triggered  <= 1'b0;
          done       <= 1'b0;
          first_wait <= (bus.pre_count_i == '0);
          state      <= (bus.pre_count_i == '0) ?
                        S_WAIT : S_PRE;
        end
        default: begin
          case (state)
            S_PRE: begin
              wr_ptr <= wr_ptr + 1'b1;
              fill   <= fill + 1'b1;
              if (fill + 1'b1 == cfg.pre) begin
                state      <= S_WAIT;
                first_wait <= 1'b1;
              end
            end
            S_WAIT: begin
              wr_ptr     <= wr_ptr + 1'b1;
              first_wait <= 1'b0;
              if (hit) begin
                occ <= occ_inc;
              end
              if (fire) begin
                trig_addr <= wr_ptr;
                triggered <= 1'b1;
                post_left <= post_init;
                if (post_init == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  state <= S_POST;
                end
              end
            end
            S_POST: begin
              wr_ptr    <= wr_ptr + 1'b1;
              post_left <= post_left - 1'b1;
              if (post_left == AW'(1)) begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

  assign bus.state_o     = state;
  assign bus.triggered_o = triggered;
  assign bus.done_o      = done;
  assign bus.trig_pos_o  = cfg.pre;
  assign bus.rd_data_o   = rd_data;
  assign bus.rd_valid_o  = rd_valid;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core at WIDTH=8, DEPTH=16.
// Expected values are hand-derived from the capture timing.
module tb_la_capture_core;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pmode = 0;
  int   n;
  int   tn;

  la_capture_core_if #(.WIDTH(8), .DEPTH(16)) bus ();

  la_capture_core #(.WIDTH(8), .DEPTH(16)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.arm_i   = 1'b0;
    bus.abort_i = 1'b0;
    if (pmode == 1) bus.probe_i = bus.probe_i + 8'd1;
  endtask

  task automatic arm(input logic [1:0] m,
                     input logic [7:0] v,
                     input logic [7:0] k,
                     input logic [3:0] p,
                     input logic [3:0] t);
    bus.trig_mode_i  = m;
    bus.trig_value_i = v;
    bus.trig_mask_i  = k;
    bus.pre_count_i  = p;
    bus.trig_count_i = t;
    bus.arm_i        = 1'b1;
  endtask

  task automatic run_to_done(output int cnt, output int tcnt);
    cnt  = 0;
    tcnt = -1;
    do begin
      cyc();
      cnt++;
      if (tcnt < 0 && bus.triggered_o) tcnt = cnt;
    end while (!bus.done_o && cnt < 200);
  endtask

  task automatic rd(input logic [3:0] a,
                    input logic [7:0] exp,
                    input string tag);
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = a;
    cyc();
    chk({tag, "_valid"}, 32'(bus.rd_valid_o), 32'd1);
    chk({tag, "_data"}, 32'(bus.rd_data_o), 32'(exp));
  endtask

  initial begin
    rst              = 1'b1;
    bus.probe_i      = 8'h00;
    bus.arm_i        = 1'b0;
    bus.abort_i      = 1'b0;
    bus.trig_mode_i  = 2'b00;
    bus.trig_value_i = 8'h00;
    bus.trig_mask_i  = 8'h00;
    bus.pre_count_i  = 4'd0;
    bus.trig_count_i = 4'd0;
    bus.rd_en_i      = 1'b0;
    bus.rd_addr_i    = 4'd0;
    cyc();
    cyc();
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_trig", 32'(bus.triggered_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_pos", 32'(bus.trig_pos_o), 32'd0);
    chk("rst_rdv", 32'(bus.rd_valid_o), 32'd0);
    chk("rst_rdd", 32'(bus.rd_data_o), 32'd0);
    rst = 1'b0;
    cyc();

    // value trigger on 0x2A, pre 4
    bus.probe_i = 8'h20;
    pmode = 1;
    arm(2'b00, 8'h2A, 8'hFF, 4'd4, 4'd1);
    cyc();
    chk("v_pre", 32'(bus.state_o), 32'd1);
    run_to_done(n, tn);
    pmode = 0;
    chk("v_done_cyc", 32'(n), 32'd21);
    chk("v_trig_cyc", 32'(tn), 32'd10);
    chk("v_pos", 32'(bus.trig_pos_o), 32'd4);
    chk("v_state", 32'(bus.state_o), 32'd4);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 8'(8'h26 + i), "v_rd");
    end
    bus.rd_en_i = 1'b0;
    cyc();
    chk("v_rd_end_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("v_rd_hold", 32'(bus.rd_data_o), 32'h35);

    // third rising edge of bit0, pre 0, armed from DONE
    bus.probe_i = 8'h40;
    pmode = 1;
    arm(2'b01, 8'h00, 8'h01, 4'd0, 4'd3);
    cyc();
    chk("e_wait", 32'(bus.state_o), 32'd2);
    chk("e_done_clr", 32'(bus.done_o), 32'd0);
    run_to_done(n, tn);
    pmode = 0;
    chk("e_done_cyc", 32'(n), 32'd20);
    chk("e_trig_cyc", 32'(tn), 32'd5);
    chk("e_pos", 32'(bus.trig_pos_o), 32'd0);
    rd(4'd0, 8'h45, "e_rd0");
    rd(4'd1, 8'h46, "e_rd1");
    bus.rd_en_i = 1'b0;

    // pre 15 with forced trigger: DONE on trigger cycle
    bus.probe_i = 8'h60;
    pmode = 1;
    arm(2'b11, 8'h00, 8'h00, 4'hF, 4'd1);
    cyc();
    chk("p_pre", 32'(bus.state_o), 32'd1);
    chk("p_trig_clr", 32'(bus.triggered_o), 32'd0);
    run_to_done(n, tn);
    pmode = 0;
    chk("p_done_cyc", 32'(n), 32'd16);
    chk("p_trig_cyc", 32'(tn), 32'd16);
    chk("p_pos", 32'(bus.trig_pos_o), 32'd15);
    rd(4'd15, 8'h70, "p_rd15");
    rd(4'd0, 8'h61, "p_rd0");
    bus.rd_en_i = 1'b0;

    // 40 WAIT cycles before trigger, pre 8: buffer wraps
    bus.probe_i = 8'h00;
    pmode = 1;
    arm(2'b00, 8'h31, 8'hFF, 4'd8, 4'd1);
    cyc();
    run_to_done(n, tn);
    pmode = 0;
    chk("w_done_cyc", 32'(n), 32'd56);
    chk("w_trig_cyc", 32'(tn), 32'd49);
    chk("w_pos", 32'(bus.trig_pos_o), 32'd8);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 8'(8'h29 + i), "w_rd");
    end
    bus.rd_en_i = 1'b0;

    // abort in POST
    arm(2'b11, 8'h00, 8'h00, 4'd0, 4'd1);
    cyc();
    chk("a_wait_1cyc", 32'(bus.state_o), 32'd2);
    cyc();
    chk("a_post", 32'(bus.state_o), 32'd3);
    chk("a_post_trig", 32'(bus.triggered_o), 32'd1);
    bus.abort_i = 1'b1;
    cyc();
    chk("a_idle", 32'(bus.state_o), 32'd0);
    chk("a_trig", 32'(bus.triggered_o), 32'd0);
    chk("a_done", 32'(bus.done_o), 32'd0);

    // readout gated outside DONE
    bus.rd_en_i = 1'b1;
    bus.rd_addr_i = 4'd0;
    cyc();
    chk("g_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("g_hold", 32'(bus.rd_data_o), 32'h38);
    bus.rd_en_i = 1'b0;

    // arm in WAIT ignored, arm+abort aborts
    bus.probe_i = 8'h00;
    arm(2'b00, 8'hFF, 8'hFF, 4'd0, 4'd1);
    cyc();
    chk("c_wait", 32'(bus.state_o), 32'd2);
    arm(2'b00, 8'h00, 8'h00, 4'd5, 4'd1);
    cyc();
    chk("c_arm_ign", 32'(bus.state_o), 32'd2);
    chk("c_arm_pos", 32'(bus.trig_pos_o), 32'd0);
    cyc();
    chk("c_still_wait", 32'(bus.state_o), 32'd2);
    arm(2'b00, 8'hFF, 8'hFF, 4'd0, 4'd1);
    bus.abort_i = 1'b1;
    cyc();
    chk("c_arm_abort", 32'(bus.state_o), 32'd0);

    // reset in WAIT
    arm(2'b00, 8'hFF, 8'hFF, 4'd3, 4'd1);
    cyc();
    chk("r_pre", 32'(bus.state_o), 32'd1);
    repeat (4) cyc();
    chk("r_wait", 32'(bus.state_o), 32'd2);
    rst = 1'b1;
    cyc();
    chk("r_state", 32'(bus.state_o), 32'd0);
    chk("r_pos", 32'(bus.trig_pos_o), 32'd0);
    chk("r_rdd", 32'(bus.rd_data_o), 32'd0);
    chk("r_done", 32'(bus.done_o), 32'd0);
    chk("r_trig", 32'(bus.triggered_o), 32'd0);
    rst = 1'b0;
    cyc();
    chk("r_idle", 32'(bus.state_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised on-chip logic-analyser capture engine; next generation of the single-probe capture core behind the JTAG debug hub.
- Samples a WIDTH-bit probe bus every clock into a circular buffer of DEPTH entries.
- Adds programmable trigger modes, occurrence counting, a pre-trigger window and a random-access readout port.
- Sits between user probe nets and the control/readout register layer driven by the JTAG controller.

Parameters:
WIDTH, 8, probe bus width in bits (1..256)
DEPTH, 1024, buffer depth in samples; power of two, 16..65536
AW, derived localparam = clog2(DEPTH), buffer address width

Ports:
clk_i  in  1  sample/system clock
rst_i  in  1  synchronous reset, active-high
probe_i  in  WIDTH  probe bus, sampled every cycle
arm_i  in  1  single-cycle pulse: latch config, start capture
abort_i  in  1  single-cycle pulse: return to IDLE
trig_mode_i  in  2  00 value match, 01 rising edge, 10 falling edge, 11 force
trig_value_i  in  WIDTH  compare value (mode 00)
trig_mask_i  in  WIDTH  bits taking part in the trigger (1 = compared)
pre_count_i  in  AW  samples kept before the trigger sample
trig_count_i  in  4  trigger occurrences required; 0 treated as 1
rd_en_i  in  1  readout request
rd_addr_i  in  AW  readout index, 0 = oldest sample of frame
rd_data_o  out  WIDTH  readout data
rd_valid_o  out  1  rd_data_o valid
state_o  out  3  0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
triggered_o  out  1  high from the trigger sample until IDLE
done_o  out  1  high in DONE
trig_pos_o  out  AW  readout index of trigger sample (= latched pre_count)

Behaviour:
- Reset (rst_i high at clock edge): state IDLE; all outputs 0; write pointer, fill and occurrence counters 0; prev-sample register 0. Buffer contents are undefined.
- On arm, the engine latches mode, value, mask, pre_count and trig_count. Later input changes have no effect until the next arm.
- pre_count_i above DEPTH-1 is clamped to DEPTH-1.
- prev-sample register loads probe_i every cycle in every state.
- Buffer write: probe_i is written at wr_ptr every cycle in PRE, WAIT and POST. wr_ptr increments modulo DEPTH. No writes occur in IDLE or DONE.
- IDLE:
  - arm_i -> PRE, wr_ptr = 0, fill = 0.
  - If the latched pre_count is 0, go to WAIT directly.
- PRE: fill increments per write; when fill reaches pre_count -> WAIT.
- WAIT: the trigger condition is evaluated on the current probe_i.
  - Mode 00: (probe & mask) == (value & mask).
  - Mode 01: any masked bit has prev = 0 and cur = 1.
  - Mode 10: any masked bit has prev = 1 and cur = 0.
  - Mode 11: true on the first WAIT cycle.
  - Each true cycle increments the occurrence counter.
  - The cycle the counter reaches the latched trig_count is the trigger sample: it is written, trig_addr = wr_ptr, triggered_o rises next cycle, go to POST with post_left = DEPTH-1-pre_count.
  - If post_left = 0, go straight to DONE.
  - The buffer keeps wrapping while in WAIT; older samples are overwritten.
- POST: post_left decrements per write; the cycle it reaches 0 -> DONE.
- DONE:
  - Frame holds exactly DEPTH samples.
  - start = (trig_addr - pre_count) mod DEPTH.
  - done_o = 1.
- Readout: rd_en_i in DONE reads physical address (start + rd_addr_i) mod DEPTH.
  - rd_data_o and rd_valid_o appear 1 cycle later (1-cycle latency).
  - rd_valid_o is a single-cycle pulse per request.
  - rd_en_i outside DONE gives rd_valid_o = 0 and rd_data_o holds its value.
- Control precedence:
  - abort_i in any state -> IDLE and clears triggered_o and done_o.
  - abort_i together with arm_i: abort wins.
  - arm_i in PRE, WAIT or POST is ignored.
  - arm_i in DONE restarts capture exactly as from IDLE.
- rst_i asserted mid-capture overrides everything and returns to the reset state next cycle.
- Occurrence counter is 4 bits, cleared on arm, and saturates; it never wraps.
- All pointer arithmetic is modulo DEPTH on AW bits.

Test Plan (WIDTH=8, DEPTH=16):
- Value trigger: mode 00, mask FF, value 0x2A, pre 4, tc 1. Probe counts 0x20 upward, one per cycle. Expected: DONE after 0x2A + 11 samples; trig_pos_o = 4; rd_addr 0..15 returns 0x26..0x35.
- Rising edge with occurrence count: mode 01, mask 0x01, probe toggles bit0 every cycle, tc 3, pre 0. Expected: trigger on the third 0->1 transition; rd_addr 0 returns that sample; triggered_o high 1 cycle after it.
- Boundary pre counts: pre_count_i = 15 gives DONE on the trigger cycle with trigger at index 15. pre_count_i = 0 goes IDLE -> WAIT in 1 cycle. pre_count_i = 0xFF is clamped to 15.
- Wrap-around: WAIT lasts 40 cycles before trigger (pre 8). Expected: readout is contiguous 16 samples, 8 before the trigger and 7 after; no stale data.
- Control: abort in POST -> IDLE, done_o 0, triggered_o 0. Arm in WAIT is ignored (state unchanged). Arm plus abort together -> IDLE. Arm in DONE -> PRE with a new frame.
- Reset and readout gating: rst_i in WAIT -> state 0, all outputs 0 next cycle. rd_en_i in IDLE -> rd_valid_o stays 0. Back-to-back rd_en_i in DONE -> rd_valid_o high each following cycle.
